// File: rtl/btb_pkg.sv
// btb_pkg: shared constants and the saturating-counter step used by the branch target buffer.
package btb_pkg;
   localparam int ADDR_W_DEF = 16;
   localparam int PRED_ANY_HIT = 0;
   localparam int PRED_CTR_MSB = 1;
   // Counters are at most 4 bits wide, so the step works on a 4-bit value and w selects the ceiling.
   function automatic logic [3:0] sat_step(input logic [3:0] c, input logic up, input int w);
      logic [3:0] mx;
      mx = 4'((5'd1 << w) - 5'd1);
      return up ? ((c == mx) ? c : c + 4'd1) : ((c == 4'd0) ? c : c - 4'd1);
   endfunction
endpackage

// File: rtl/btb_sat_counter.sv
// btb_sat_counter: CTR_W-wide saturating up/down step, shared by the update path.
module btb_sat_counter
   import btb_pkg::*;
#(
   parameter int CTR_W = 2
) (
   input  logic [CTR_W-1:0] ctr,
   input  logic             up,
   output logic [CTR_W-1:0] next
);
   assign next = CTR_W'(sat_step(4'(ctr), up, CTR_W));
endmodule

// File: rtl/branch_target_buffer.sv
// branch_target_buffer: direct-mapped BTB with combinational lookup and registered updates.
module branch_target_buffer
   import btb_pkg::*;
#(
   parameter int ADDR_W    = ADDR_W_DEF,
   parameter int ENTRIES   = 16,
   parameter int CTR_W     = 2,
   parameter int PRED_MODE = PRED_CTR_MSB
) (
   input  logic              clk,
   input  logic              reset,
   input  logic [ADDR_W-1:0] lookup_pc,
   output logic              pred_hit,
   output logic              pred_taken,
   output logic [ADDR_W-1:0] pred_target,
   input  logic              upd_valid,
   input  logic [ADDR_W-1:0] upd_pc,
   input  logic              upd_taken,
   input  logic [ADDR_W-1:0] upd_target,
   input  logic              flush_all
);
   localparam int IDX_W = $clog2(ENTRIES);
   localparam int TAG_W = ADDR_W - IDX_W;
   logic [ENTRIES-1:0] valid;
   logic [TAG_W-1:0]   tag    [ENTRIES];
   logic [ADDR_W-1:0]  target [ENTRIES];
   logic [CTR_W-1:0]   ctr    [ENTRIES];
   logic [IDX_W-1:0]   li, ui;
   logic [TAG_W-1:0]   lt, ut;
   logic               upd_hit;
   logic [CTR_W-1:0]   ctr_next;
   assign li = lookup_pc[IDX_W-1:0];
   assign lt = lookup_pc[ADDR_W-1:IDX_W];
   assign ui = upd_pc[IDX_W-1:0];
   assign ut = upd_pc[ADDR_W-1:IDX_W];
   assign pred_hit    = valid[li] && (tag[li] == lt);
   assign pred_taken  = pred_hit && (PRED_MODE == PRED_ANY_HIT || ctr[li][CTR_W-1]);
   assign pred_target = pred_taken ? target[li] : '0;
   assign upd_hit     = valid[ui] && (tag[ui] == ut);
   btb_sat_counter #(.CTR_W(CTR_W)) u_ctr (
      .ctr  (ctr[ui]),
      .up   (upd_taken),
      .next (ctr_next)
   );
   always_ff @(posedge clk or posedge reset)
      if (reset) begin
         valid <= '0;
         for (int i = 0; i < ENTRIES; i++) ctr[i] <= '0;
      end else if (flush_all) begin
         valid <= '0;
      end else if (upd_valid && (upd_hit || upd_taken)) begin
         valid[ui] <= 1'b1;
         ctr[ui]   <= upd_hit ? ctr_next : CTR_W'(1 << (CTR_W - 1));
      end
   // Tag/target need no reset; a taken update rewrites them whether it hits or allocates.
   always_ff @(posedge clk)
      if (!reset && !flush_all && upd_valid && upd_taken) begin
         tag[ui]    <= ut;
         target[ui] <= upd_target;
      end
endmodule

// File: tb/tb_branch_target_buffer.sv
// tb_branch_target_buffer: scoreboard bench driving a default BTB and a 4-entry any-hit BTB in parallel.
module tb_branch_target_buffer;
   logic        clk = 0, reset = 0;
   logic [15:0] lookup_pc = '0, upd_pc = '0, upd_target = '0;
   logic        upd_valid = 0, upd_taken = 0, flush_all = 0;
   logic        hit0, taken0, hit1, taken1;
   logic [15:0] tgt0, tgt1;
   int vectors = 0, miscompares = 0, cyc = 0;

   always #5 clk = ~clk;

   branch_target_buffer dut0 (
      .clk(clk), .reset(reset), .lookup_pc(lookup_pc), .pred_hit(hit0), .pred_taken(taken0),
      .pred_target(tgt0), .upd_valid(upd_valid), .upd_pc(upd_pc), .upd_taken(upd_taken),
      .upd_target(upd_target), .flush_all(flush_all));
   branch_target_buffer #(.ENTRIES(4), .PRED_MODE(0)) dut1 (
      .clk(clk), .reset(reset), .lookup_pc(lookup_pc), .pred_hit(hit1), .pred_taken(taken1),
      .pred_target(tgt1), .upd_valid(upd_valid), .upd_pc(upd_pc), .upd_taken(upd_taken),
      .upd_target(upd_target), .flush_all(flush_all));

   typedef struct {
      int               cyc;
      logic [1:0]       h, tk;
      logic [1:0][15:0] tg;
   } exp_t;
   exp_t q[$];

   // Reference model: per-instance tables indexed by pc mod entries, tag = pc div entries.
   bit          mv  [2][16];
   int          mt  [2][16];
   logic [15:0] mtg [2][16];
   int          mc  [2][16];

   function automatic int ents(int k);
      return k ? 4 : 16;
   endfunction

   function automatic void model_reset();
      for (int k = 0; k < 2; k++)
         for (int i = 0; i < 16; i++) begin
            mv[k][i] = 0;
            mc[k][i] = 0;
         end
   endfunction

   function automatic void model_lookup(int k, logic [15:0] pc, output logic h, output logic tk,
                                        output logic [15:0] tg);
      int i, t;
      i  = int'(pc) % ents(k);
      t  = int'(pc) / ents(k);
      h  = mv[k][i] && mt[k][i] == t;
      tk = h && (k == 1 || mc[k][i] >= 2);
      tg = tk ? mtg[k][i] : 16'h0;
   endfunction

   function automatic void model_update(int k, logic uv, logic [15:0] pc, logic ut, logic [15:0] tgt,
                                        logic fl);
      int i, t;
      i = int'(pc) % ents(k);
      t = int'(pc) / ents(k);
      if (fl) begin
         for (int j = 0; j < 16; j++) mv[k][j] = 0;
      end else if (uv) begin
         if (mv[k][i] && mt[k][i] == t) begin
            if (ut) begin
               mc[k][i]  = (mc[k][i] == 3) ? 3 : mc[k][i] + 1;
               mtg[k][i] = tgt;
            end else mc[k][i] = (mc[k][i] == 0) ? 0 : mc[k][i] - 1;
         end else if (ut) begin
            mv[k][i]  = 1;
            mt[k][i]  = t;
            mtg[k][i] = tgt;
            mc[k][i]  = 2;
         end
      end
   endfunction

   // Called at posedge+1: presents one cycle of inputs, queues expectations, advances to next posedge+1.
   task automatic step(logic [15:0] lpc, logic uv, logic [15:0] upc, logic ut, logic [15:0] utg, logic fl);
      exp_t e;
      lookup_pc = lpc; upd_valid = uv; upd_pc = upc; upd_taken = ut; upd_target = utg; flush_all = fl;
      e.cyc = cyc++;
      for (int k = 0; k < 2; k++) model_lookup(k, lpc, e.h[k], e.tk[k], e.tg[k]);
      q.push_back(e);
      for (int k = 0; k < 2; k++) model_update(k, uv, upc, ut, utg, fl);
      @(posedge clk);
      #1;
   endtask

   task automatic chk(string name, logic [17:0] got, logic [17:0] exp);
      vectors++;
      if (got !== exp) begin
         miscompares++;
         $display("FAIL %s: got %h required %h", name, got, exp);
      end
   endtask

   exp_t me;
   always @(negedge clk)
      if (q.size() > 0) begin
         logic [1:0]       gh, gt;
         logic [1:0][15:0] gg;
         me = q.pop_front();
         gh = {hit1, hit0};
         gt = {taken1, taken0};
         gg = {tgt1, tgt0};
         for (int k = 0; k < 2; k++) begin
            vectors++;
            if ({gh[k], gt[k], gg[k]} !== {me.h[k], me.tk[k], me.tg[k]}) begin
               miscompares++;
               $display("FAIL cyc%0d dut%0d hit/taken/target: got %b/%b/%h required %b/%b/%h",
                        me.cyc, k, gh[k], gt[k], gg[k], me.h[k], me.tk[k], me.tg[k]);
            end
         end
      end

   initial begin
      logic [15:0] pool [8];
      logic h, tk;
      logic [15:0] tg;
      pool = '{16'h0043, 16'h0053, 16'h0001, 16'h0005, 16'h0007, 16'h0013, 16'h1043, 16'h0000};
      lookup_pc = 16'h0040; upd_valid = 1; upd_pc = 16'h0040; upd_taken = 1; upd_target = 16'h0999;
      #1 reset = 1;
      model_reset();
      #2;
      chk("reset_out0", {hit0, taken0, tgt0}, 18'h0);
      chk("reset_out1", {hit1, taken1, tgt1}, 18'h0);
      repeat (2) @(posedge clk);
      #1;
      chk("reset_hold_upd_ignored", {hit0, taken0, tgt0}, 18'h0);
      reset = 0;
      step(16'h0043, 1, 16'h0043, 1, 16'h0100, 0);
      step(16'h0043, 0, 16'h0000, 0, 16'h0000, 0);
      step(16'h0053, 0, 16'h0000, 0, 16'h0000, 0);
      step(16'h0043, 1, 16'h0043, 0, 16'h0000, 0);
      step(16'h0043, 1, 16'h0043, 0, 16'h0000, 0);
      step(16'h0043, 1, 16'h0043, 1, 16'h0100, 0);
      step(16'h0043, 1, 16'h0043, 1, 16'h0100, 0);
      step(16'h0043, 1, 16'h0043, 1, 16'h0100, 0);
      step(16'h0043, 1, 16'h0043, 1, 16'h0100, 0);
      step(16'h0043, 1, 16'h0043, 0, 16'h0000, 0);
      step(16'h0043, 1, 16'h0043, 1, 16'h0200, 0);
      step(16'h0043, 0, 16'h0000, 0, 16'h0000, 0);
      step(16'h0001, 1, 16'h0001, 1, 16'h0aa0, 0);
      step(16'h0001, 1, 16'h0001, 0, 16'h0000, 0);
      step(16'h0001, 1, 16'h0005, 1, 16'h0bb0, 0);
      step(16'h0001, 0, 16'h0000, 0, 16'h0000, 0);
      step(16'h0005, 1, 16'h0007, 1, 16'h0300, 1);
      step(16'h0007, 0, 16'h0000, 0, 16'h0000, 0);
      step(16'h0043, 0, 16'h0000, 0, 16'h0000, 0);
      step(16'h0005, 1, 16'h0043, 1, 16'h0440, 0);
      @(negedge clk);
      #1;
      lookup_pc = 16'h0043; upd_valid = 0; flush_all = 0;
      @(posedge clk);
      #1;
      model_lookup(0, 16'h0043, h, tk, tg);
      chk("pre_async_reset_hit", {hit0, taken0, tgt0}, {h, tk, tg});
      #1 reset = 1;
      #1;
      chk("async_reset_midcycle0", {hit0, taken0, tgt0}, 18'h0);
      chk("async_reset_midcycle1", {hit1, taken1, tgt1}, 18'h0);
      reset = 0;
      model_reset();
      @(posedge clk);
      #1;
      for (int n = 0; n < 400; n++) begin
         logic [15:0] lpc, upc;
         lpc = pool[$urandom_range(0, 7)];
         upc = pool[$urandom_range(0, 7)];
         if ($urandom_range(0, 7) == 0) lpc = 16'($urandom);
         step(lpc, $urandom_range(0, 9) < 7, upc, 1'($urandom), 16'($urandom), $urandom_range(0, 39) == 0);
      end
      upd_valid = 0;
      flush_all = 0;
      repeat (3) @(negedge clk);
      vectors++;
      if (q.size() != 0) begin
         miscompares++;
         $display("FAIL drain: got %0d pending required 0", q.size());
      end
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout required completion");
      $fatal(1, "timeout");
   end
endmodule

// File: doc/branch_target_buffer.md
BRANCH_TARGET_BUFFER -- requirements
Module: branch_target_buffer

Interface
REQ-001 The block SHALL have parameter ADDR_W, default 16, meaning the instruction address and target width in bits.
REQ-002 The block SHALL have parameter ENTRIES, default 16, meaning the number of direct-mapped entries; it must be a power of two, >=2.
REQ-003 The block SHALL have parameter CTR_W, default 2, meaning the saturating counter width; legal range 1..4.
REQ-004 The block SHALL have parameter PRED_MODE, default 1, meaning 0 = predict taken on any hit, 1 = use counter MSB.
REQ-005 The block SHALL have port clk, input, 1 bit: the single clock, rising edge.
REQ-006 The block SHALL have port reset, input, 1 bit: asynchronous, active-high reset.
REQ-007 The block SHALL have port lookup_pc, input, ADDR_W bits: the fetch-stage PC.
REQ-008 The block SHALL have port pred_hit, output, 1 bit: a valid entry matches lookup_pc.
REQ-009 The block SHALL have port pred_taken, output, 1 bit: the branch is predicted taken (BRANCH_PRED).
REQ-010 The block SHALL have port pred_target, output, ADDR_W bits: the predicted target (TARGET); all zeros when pred_taken=0.
REQ-011 The block SHALL have port upd_valid, input, 1 bit: a resolved-branch update is present this cycle.
REQ-012 The block SHALL have port upd_pc, input, ADDR_W bits: the PC of the resolved branch.
REQ-013 The block SHALL have port upd_taken, input, 1 bit: the resolved direction.
REQ-014 The block SHALL have port upd_target, input, ADDR_W bits: the resolved target.
REQ-015 The block SHALL have port flush_all, input, 1 bit: invalidate every entry.

Function
REQ-016 Index SHALL be pc[IDX_W-1:0] with IDX_W=log2(ENTRIES); tag SHALL be pc[ADDR_W-1:IDX_W].
REQ-017 Each entry SHALL hold valid, tag, target (ADDR_W) and ctr (CTR_W).
REQ-018 Lookup SHALL be combinational with zero latency: pred_hit = valid && tag match; pred_taken = pred_hit && (PRED_MODE==0 || ctr MSB==1).
REQ-019 Updates SHALL be registered: state changes take effect at the rising clk edge after upd_valid=1 and are visible to lookup the following cycle.
REQ-020 Update hit with taken: ctr SHALL increment, saturating at 2^CTR_W-1, and target SHALL be overwritten with upd_target.
REQ-021 Update hit with not-taken: ctr SHALL decrement, saturating at 0; target SHALL remain unchanged.
REQ-022 Update miss with taken: the entry SHALL be allocated, overwriting any occupant: valid=1, tag, target, ctr=2^(CTR_W-1) (weakly taken).
REQ-023 Update miss with not-taken: there SHALL be no state change.
REQ-024 Lookup and update to the same index in the same cycle: lookup SHALL return the pre-update contents (no bypass).
REQ-025 flush_all=1 SHALL clear every valid bit at the next edge and take priority over a simultaneous update, which is dropped.
REQ-026 Tag, target and ctr SHALL be retained across flush_all and SHALL be ignored while the entry is invalid.

Reset
REQ-027 Asserting reset SHALL immediately clear all valid bits and set all ctr to 0, regardless of clk.
REQ-028 While reset is asserted: pred_hit=0, pred_taken=0, pred_target=0, and updates are ignored.
REQ-029 Tag and target storage SHALL need no reset.
REQ-030 The first update SHALL be accepted on the first rising edge after reset deasserts.

Structure
REQ-031 A shared core package SHALL hold ADDR_W default, the PRED_MODE encodings and a ctr saturating-update function.
REQ-032 One sub-module, btb_sat_counter (CTR_W-wide saturating up/down), is natural and SHALL be instantiated per entry or as a shared update path.
REQ-033 Storage SHALL be flops, not inferred RAM, because the read is asynchronous.

Verification
REQ-034 Defaults, after reset: lookup_pc=0x0040 -> pred_hit=0, pred_taken=0, pred_target=0x0000.
REQ-035 Update pc=0x0043, taken, target=0x0100; next cycle lookup 0x0043 -> hit=1, taken=1, target=0x0100; lookup 0x0053 -> hit=0 (tag mismatch, same index).
REQ-036 Entry at ctr=2, then two not-taken updates -> ctr=0, pred_taken=0, pred_hit=1; three taken updates -> ctr=3, and a fourth taken update leaves ctr at 3.
REQ-037 PRED_MODE=0, ENTRIES=4: allocate 0x0001, then one not-taken update -> pred_taken still 1; then alias 0x0005 taken -> 0x0001 misses.
REQ-038 Same-cycle lookup and update (taken, new target 0x0200) of pc 0x0043 -> the old target 0x0100 is returned that cycle and 0x0200 the next cycle.
REQ-039 flush_all together with an update allocating 0x0007 -> all lookups miss, including 0x0007; async reset pulsed mid-cycle -> outputs drop to 0 before the next edge.
